mipi_job_dispatcher: RTL and testbench
======================================

Name: mipi_job_dispatcher

Overview:
- Sits between verify_mipi_receiver and the miner cores.
- Captures each completed MIPI payload as a job in a 2-entry buffer and dispatches it to an idle core. Core selection is round-robin.
- Watches the receiver for frames that never terminate; pulses a resync request and counts the error.
- Keeps saturating status counters for host readback.

Parameters:
- DLEN, 6, payload length in bytes; job width JW = DLEN*8.
- NUM_CORES, 4, number of miner cores (2..8).
- RX_TIMEOUT, 1024, max cycles `receiving` may stay high before resync.
- BUSY_WAIT, 4, cycles a dispatched core stays masked while its core_busy rises.

Ports:
- rx_pixel_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- receiving  in  1  receiver frame-in-progress level.
- data_available  in  1  receiver payload-valid level; may stay high for many cycles.
- data  in  JW  receiver payload; stable while data_available is high.
- core_busy  in  NUM_CORES  per-core busy level.
- core_start  out  NUM_CORES  one-hot, 1-cycle start pulse.
- core_job  out  JW  job bus; valid in the core_start cycle and held until the next dispatch.
- rx_resync  out  1  1-cycle pulse requesting receiver resync.
- jobs_rx  out  16  jobs accepted, saturating.
- jobs_dropped  out  16  jobs lost to a full buffer, saturating.
- rx_timeouts  out  16  watchdog expiries, saturating.
- buf_level  out  2  buffer occupancy, 0..2.

Behaviour:
- **Reset.** All outputs are 0; the buffer is empty; rr_ptr = NUM_CORES-1; pending masks are clear; the watchdog is 0.
- **Capture.**
  - data_available is registered; a rising edge (curr=1, prev=0) is a push event.
  - data is written into the buffer on the push cycle.
  - Level-high without a new edge never pushes twice.
- **Buffer.**
  - 2-entry FIFO; buf_level is registered.
  - Push when level<2, or when level==2 with a pop in the same cycle: accepted, jobs_rx+1.
  - Push when level==2 with no pop: dropped, jobs_dropped+1; stored jobs are untouched.
  - Simultaneous push and pop at level 1: level stays 1 and order is preserved.
- **Eligibility.** Core i is eligible when core_busy[i]==0 and pend_cnt[i]==0.
- **Dispatch FSM.**
  - IDLE: go to SELECT when level>0.
  - SELECT:
    - Search from rr_ptr+1 modulo NUM_CORES for the first eligible core.
    - If found: pop the head, drive core_job = head, pulse core_start[i] for exactly 1 cycle, set rr_ptr=i, load pend_cnt[i]=BUSY_WAIT.
    - Next state is IDLE if the buffer is now empty, else SELECT.
    - If none is eligible, stay in SELECT.
  - Latency: data_available edge at cycle T → core_start at T+2 when a core is idle and the buffer was empty.
  - At most one dispatch per cycle; maximum rate is 1 job per cycle.
- **Pending mask.**
  - pend_cnt[i] decrements each cycle while nonzero.
  - It clears early when core_busy[i] is seen high.
  - If core_busy never rises, the core becomes eligible again after BUSY_WAIT cycles.
- **Watchdog.**
  - Counts cycles while receiving==1 and clears when receiving==0.
  - On reaching RX_TIMEOUT: pulse rx_resync for 1 cycle, rx_timeouts+1, counter back to 0.
  - It re-fires every RX_TIMEOUT cycles if receiving stays stuck.
- **Counters.** All counters saturate at 16'hFFFF and never wrap.
- **Mid-operation reset.** Reset has priority over every event. A push, pop or start coinciding with reset is discarded; core_start is 0 in the cycle after reset.

Decomposition:
- Shared package mipi_pkg holds:
  - SOF constants 24'hEAFF99 and 24'h99FFEA;
  - the JW function of DLEN;
  - the dispatcher state encoding (IDLE=1'b0, SELECT=1'b1);
  - the counter width constant CNT_W=16.
- One sub-module, rr_idle_picker: combinational round-robin first-eligible search that returns a one-hot grant, the index, and a found flag. It is reusable for other core-sharing arbiters.

Test Plan:
- **Single job.** After reset, core_busy=0, data_available rises with data=48'h0123456789AB. Expect core_start=4'b0001 two cycles later, core_job=48'h0123456789AB, jobs_rx=1, buf_level back to 0.
- **Round-robin.** Four jobs spaced 20 cycles apart; each started core raises core_busy one cycle after core_start. Expect core_start 0001,0010,0100,1000. A fifth job after core0 frees goes to core0.
- **Full buffer.** core_busy=4'b1111, three data_available edges. Expect buf_level=2, jobs_rx=2, jobs_dropped=1. Release core2: the first job goes to core2, and the second job goes out after the next release.
- **Level hold.** data_available held high for 40 cycles, then low, then high again. Expect exactly 2 pushes.
- **Busy-never-rises.** Core0 ignores start. Expect core0 masked for BUSY_WAIT=4 cycles; the next buffered job goes to core1 in the meantime.
- **Watchdog and reset.** receiving held high for 2100 cycles: rx_resync pulses at 1024 and 2048, rx_timeouts=2. Then assert reset one cycle before a pending dispatch: no core_start, all counters 0.

Source files
------------

// File: rtl/mipi_pkg.sv
// Shared constants, types and helpers for the MIPI receive / job dispatch path.
package mipi_pkg;
    localparam logic [23:0] SOF_A = 24'hEAFF99;
    localparam logic [23:0] SOF_B = 24'h99FFEA;
    localparam int          CNT_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SELECT = 1'b1
    } disp_state_t;

    function automatic int job_width(input int dlen);
        return dlen * 8;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/mipi_job_dispatcher_if.sv
// Receiver, core and status signals of the job dispatcher bundled as one interface.
interface mipi_job_dispatcher_if #(
    parameter int DLEN      = 6,
    parameter int NUM_CORES = 4
);
    localparam int JW = mipi_pkg::job_width(DLEN);

    logic                        receiving;
    logic                        data_available;
    logic [JW-1:0]               data;
    logic [NUM_CORES-1:0]        core_busy;
    logic [NUM_CORES-1:0]        core_start;
    logic [JW-1:0]               core_job;
    logic                        rx_resync;
    logic [mipi_pkg::CNT_W-1:0]  jobs_rx;
    logic [mipi_pkg::CNT_W-1:0]  jobs_dropped;
    logic [mipi_pkg::CNT_W-1:0]  rx_timeouts;
    logic [1:0]                  buf_level;

    modport slave (
        input  receiving, data_available, data, core_busy,
        output core_start, core_job, rx_resync, jobs_rx, jobs_dropped, rx_timeouts, buf_level
    );

    modport master (
        output receiving, data_available, data, core_busy,
        input  core_start, core_job, rx_resync, jobs_rx, jobs_dropped, rx_timeouts, buf_level
    );
endinterface

// File: rtl/mipi_job_dispatcher_rr_idle_picker.sv
// Round-robin first-eligible search starting just after i_ptr; purely combinational.
module rr_idle_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_elig,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);
    localparam int IW = $clog2(N);

    always_comb begin
        logic          w_hit;
        logic [IW-1:0] w_j;
        w_hit   = 1'b0;
        w_j     = '0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (!w_hit && i_elig[w_j]) begin
                w_hit      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
        o_found = w_hit;
    end
endmodule

// File: rtl/mipi_job_dispatcher.sv
// Buffers completed MIPI payloads (2 deep), dispatches them round-robin to idle
// miner cores, and watches the receiver for frames that never end.
module mipi_job_dispatcher
    import mipi_pkg::*;
#(
    parameter int DLEN       = 6,
    parameter int NUM_CORES  = 4,
    parameter int RX_TIMEOUT = 1024,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  rx_pixel_clk,
    input  logic                  reset,
    mipi_job_dispatcher_if.slave  bus
);
    localparam int JW = job_width(DLEN);
    localparam int IW = $clog2(NUM_CORES);
    localparam int PW = $clog2(BUSY_WAIT + 1);
    localparam int WW = $clog2(RX_TIMEOUT + 1);

    disp_state_t                     r_state, w_state_nxt;
    logic                            r_dav;
    logic [JW-1:0]                   r_mem [2];
    logic                            r_rd, r_wr;
    logic [1:0]                      r_level, w_level_nxt;
    logic [NUM_CORES-1:0]            r_core_start;
    logic [JW-1:0]                   r_core_job;
    logic [IW-1:0]                   r_rr;
    logic [NUM_CORES-1:0][PW-1:0]    r_pend;
    logic [WW-1:0]                   r_wd;
    logic                            r_resync;
    logic [CNT_W-1:0]                r_jobs_rx, r_jobs_dropped, r_timeouts;

    logic                            w_push, w_pop, w_accept, w_drop, w_found;
    logic [NUM_CORES-1:0]            w_elig, w_grant;
    logic [IW-1:0]                   w_idx;
    logic [JW-1:0]                   w_head;

    assign w_push   = bus.data_available & ~r_dav;
    assign w_accept = w_push & ((r_level != 2'd2) | w_pop);
    assign w_drop   = w_push & (r_level == 2'd2) & ~w_pop;
    assign w_head   = r_mem[r_rd];

    // A core is masked both while busy and for a short window after its start,
    // so a core that is slow to raise core_busy is not handed a second job.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_CORES; i++)
            w_elig[i] = ~bus.core_busy[i] & (r_pend[i] == '0);
    end

    rr_idle_picker #(.N(NUM_CORES)) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE:   if (r_level != 2'd0) w_state_nxt = SELECT;
            SELECT: if (w_found && r_level != 2'd0) begin
                        w_pop = 1'b1;
                        // a pop always makes room, so the only way to empty is level 1 with no push
                        w_state_nxt = (r_level == 2'd1 && !w_push) ? IDLE : SELECT;
                    end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_accept && !w_pop)      w_level_nxt = r_level + 2'd1;
        else if (!w_accept && w_pop) w_level_nxt = r_level - 2'd1;
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_dav          <= 1'b0;
            r_rd           <= 1'b0;
            r_wr           <= 1'b0;
            r_level        <= 2'd0;
            r_core_start   <= '0;
            r_core_job     <= '0;
            r_rr           <= IW'(NUM_CORES - 1);
            r_pend         <= '0;
            r_wd           <= '0;
            r_resync       <= 1'b0;
            r_jobs_rx      <= '0;
            r_jobs_dropped <= '0;
            r_timeouts     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dav   <= bus.data_available;
            r_level <= w_level_nxt;
            if (w_accept) begin
                r_mem[r_wr] <= bus.data;
                r_wr        <= ~r_wr;
                r_jobs_rx   <= sat_inc(r_jobs_rx);
            end
            if (w_drop)
                r_jobs_dropped <= sat_inc(r_jobs_dropped);
            r_core_start <= w_pop ? w_grant : '0;
            if (w_pop) begin
                r_rd       <= ~r_rd;
                r_core_job <= w_head;
                r_rr       <= w_idx;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_pop && w_grant[i])      r_pend[i] <= PW'(BUSY_WAIT);
                else if (bus.core_busy[i])    r_pend[i] <= '0;
                else if (r_pend[i] != '0)     r_pend[i] <= r_pend[i] - PW'(1);
            end
            r_resync <= 1'b0;
            if (!bus.receiving) begin
                r_wd <= '0;
            end else if (r_wd == WW'(RX_TIMEOUT - 1)) begin
                r_wd       <= '0;
                r_resync   <= 1'b1;
                r_timeouts <= sat_inc(r_timeouts);
            end else begin
                r_wd <= r_wd + WW'(1);
            end
        end
    end

    assign bus.core_start   = r_core_start;
    assign bus.core_job     = r_core_job;
    assign bus.rx_resync    = r_resync;
    assign bus.jobs_rx      = r_jobs_rx;
    assign bus.jobs_dropped = r_jobs_dropped;
    assign bus.rx_timeouts  = r_timeouts;
    assign bus.buf_level    = r_level;
endmodule

// File: tb/tb_mipi_job_dispatcher.sv
// Directed bench for mipi_job_dispatcher: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mipi_job_dispatcher;
    localparam int NC   = 4;
    localparam int JW   = 48;
    localparam int BW   = 4;
    localparam int RXT  = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mipi_job_dispatcher_if #(.DLEN(6), .NUM_CORES(NC)) bus ();

    mipi_job_dispatcher #(.DLEN(6), .NUM_CORES(NC), .RX_TIMEOUT(RXT), .BUSY_WAIT(BW)) dut (
        .rx_pixel_clk (clk),
        .reset        (rst),
        .bus          (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Core responder: auto-enabled cores raise busy one cycle after their start
    logic [NC-1:0] force_busy = '0;
    logic [NC-1:0] auto_en = '0;
    int            auto_len = 0;
    int            acnt [NC];
    logic [NC-1:0] st_d = '0;

    always @(negedge clk) begin
        logic [NC-1:0] b;
        b = force_busy;
        for (int i = 0; i < NC; i++) begin
            if (auto_en[i] && st_d[i]) acnt[i] = auto_len;
            else if (acnt[i] > 0)      acnt[i] = acnt[i] - 1;
            if (acnt[i] > 0) b[i] = 1'b1;
        end
        st_d = bus.core_start;
        bus.core_busy = b;
    end

    // Reference model: job queue, per-core mask timers, watchdog count
    logic [JW-1:0] q [$];
    logic          prev_dav, armed, chk_en = 1'b0;
    int            rr, wd, cyc = 0;
    int            pend [NC];
    logic [NC-1:0] e_start;
    logic [JW-1:0] e_job;
    logic          e_resync;
    logic [15:0]   e_rx, e_drop, e_to;
    int            e_level;

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(posedge clk) begin : model
        logic push, disp;
        int   pre, g, j;
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            prev_dav = 1'b0; armed = 1'b0; rr = NC - 1; wd = 0;
            for (int i = 0; i < NC; i++) pend[i] = 0;
            e_start = '0; e_job = '0; e_resync = 1'b0;
            e_rx = '0; e_drop = '0; e_to = '0;
            chk_en = 1'b1;
        end else begin
            push = bus.data_available && !prev_dav;
            prev_dav = bus.data_available;
            pre = q.size();
            disp = 1'b0; g = 0;
            if (armed && pre > 0)
                for (int k = 1; k <= NC; k++) begin
                    j = (rr + k) % NC;
                    if (!disp && !bus.core_busy[j] && pend[j] == 0) begin
                        disp = 1'b1; g = j;
                    end
                end
            e_start = '0;
            e_resync = 1'b0;
            if (disp) begin
                e_job = q.pop_front();
                e_start[g] = 1'b1;
                rr = g;
            end
            if (push) begin
                if (pre < 2 || disp) begin q.push_back(bus.data); e_rx = sat(e_rx); end
                else e_drop = sat(e_drop);
            end
            armed = armed ? (q.size() > 0) : (pre > 0);
            for (int i = 0; i < NC; i++) begin
                if (disp && g == i)       pend[i] = BW;
                else if (bus.core_busy[i]) pend[i] = 0;
                else if (pend[i] > 0)     pend[i] = pend[i] - 1;
            end
            if (bus.receiving) begin
                wd = wd + 1;
                if (wd == RXT) begin wd = 0; e_resync = 1'b1; e_to = sat(e_to); end
            end else wd = 0;
        end
        e_level = q.size();
    end

    // Per-cycle compare and start log
    logic [NC-1:0] log_g [$];
    logic [JW-1:0] log_j [$];
    int            log_c [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("core_start", bus.core_start, e_start);
            chk("core_job", bus.core_job, e_job);
            chk("rx_resync", bus.rx_resync, e_resync);
            chk("jobs_rx", bus.jobs_rx, e_rx);
            chk("jobs_dropped", bus.jobs_dropped, e_drop);
            chk("rx_timeouts", bus.rx_timeouts, e_to);
            chk("buf_level", bus.buf_level, e_level);
            if (bus.core_start != '0) begin
                log_g.push_back(bus.core_start);
                log_j.push_back(bus.core_job);
                log_c.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        log_g.delete(); log_j.delete(); log_c.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [JW-1:0] d);
        bus.data = d;
        bus.data_available = 1'b1;
        @(negedge clk);
        bus.data_available = 1'b0;
        @(negedge clk);
    endtask

    int pulses [$];
    int n0;

    initial begin
        rst = 1'b1;
        bus.receiving = 1'b0;
        bus.data_available = 1'b0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        chk("rst_start", bus.core_start, 4'b0000);
        chk("rst_level", bus.buf_level, 2'd0);
        chk("rst_jobs_rx", bus.jobs_rx, 16'd0);
        chk("rst_resync", bus.rx_resync, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // single job: start two edges after the push edge
        bus.data = 48'h0123456789AB;
        bus.data_available = 1'b1;
        @(negedge clk);
        chk("t1_level1", bus.buf_level, 2'd1);
        @(negedge clk);
        chk("t1_not_yet", bus.core_start, 4'b0000);
        @(negedge clk);
        chk("t1_start", bus.core_start, 4'b0001);
        chk("t1_job", bus.core_job, 48'h0123456789AB);
        chk("t1_jobs_rx", bus.jobs_rx, 16'd1);
        chk("t1_level0", bus.buf_level, 2'd0);
        bus.data_available = 1'b0;
        repeat (8) @(negedge clk);

        // round-robin
        auto_en = 4'b1111; auto_len = 50;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(48'hA0 + 48'(k));
            repeat (18) @(negedge clk);
        end
        pulse(48'hA4);
        repeat (8) @(negedge clk);
        chk("rr_count", log_g.size(), 5);
        if (log_g.size() == 5) begin
            chk("rr_0", log_g[0], 4'b0001);
            chk("rr_1", log_g[1], 4'b0010);
            chk("rr_2", log_g[2], 4'b0100);
            chk("rr_3", log_g[3], 4'b1000);
            chk("rr_4", log_g[4], 4'b0001);
            chk("rr_job4", log_j[4], 48'hA4);
        end
        repeat (60) @(negedge clk);

        // full buffer
        auto_en = '0; force_busy = 4'b1111;
        do_reset();
        pulse(48'hB1); pulse(48'hB2); pulse(48'hB3);
        repeat (3) @(negedge clk);
        chk("full_level", bus.buf_level, 2'd2);
        chk("full_rx", bus.jobs_rx, 16'd2);
        chk("full_drop", bus.jobs_dropped, 16'd1);
        auto_en = 4'b0100; auto_len = 40; force_busy = 4'b1011;
        repeat (4) @(negedge clk);
        chk("full_n1", log_g.size(), 1);
        if (log_g.size() >= 1) begin
            chk("full_g0", log_g[0], 4'b0100);
            chk("full_j0", log_j[0], 48'hB1);
        end
        chk("full_level1", bus.buf_level, 2'd1);
        force_busy = 4'b1010;
        repeat (4) @(negedge clk);
        chk("full_n2", log_g.size(), 2);
        if (log_g.size() >= 2) begin
            chk("full_g1", log_g[1], 4'b0001);
            chk("full_j1", log_j[1], 48'hB2);
        end
        force_busy = '0;
        repeat (45) @(negedge clk);

        // level hold: one push per rising edge
        auto_en = '0;
        do_reset();
        bus.data = 48'hC1; bus.data_available = 1'b1;
        repeat (40) @(negedge clk);
        bus.data_available = 1'b0;
        repeat (3) @(negedge clk);
        bus.data = 48'hC2; bus.data_available = 1'b1;
        repeat (5) @(negedge clk);
        bus.data_available = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_rx", bus.jobs_rx, 16'd2);
        chk("hold_starts", log_g.size(), 2);
        if (log_j.size() == 2) begin
            chk("hold_j0", log_j[0], 48'hC1);
            chk("hold_j1", log_j[1], 48'hC2);
        end
        repeat (10) @(negedge clk);

        // busy never rises on core0: masked BUSY_WAIT cycles, job2 goes to core1
        force_busy = 4'b1100; auto_en = 4'b0010; auto_len = 30;
        do_reset();
        pulse(48'hD1); pulse(48'hD2); pulse(48'hD3);
        repeat (10) @(negedge clk);
        chk("bw_count", log_g.size(), 3);
        if (log_g.size() == 3) begin
            chk("bw_g0", log_g[0], 4'b0001);
            chk("bw_g1", log_g[1], 4'b0010);
            chk("bw_g2", log_g[2], 4'b0001);
            chk("bw_gap", log_c[2] - log_c[0], 5);
            chk("bw_j2", log_j[2], 48'hD3);
        end
        force_busy = '0; auto_en = '0;
        repeat (35) @(negedge clk);

        // watchdog
        do_reset();
        bus.receiving = 1'b1;
        for (int j = 1; j <= 2100; j++) begin
            @(negedge clk);
            if (bus.rx_resync) pulses.push_back(j);
        end
        bus.receiving = 1'b0;
        chk("wd_n", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("wd_p0", pulses[0], 1024);
            chk("wd_p1", pulses[1], 2048);
        end
        chk("wd_count", bus.rx_timeouts, 16'd2);

        // reset lands on the dispatch edge
        @(negedge clk);
        bus.data = 48'hE1; bus.data_available = 1'b1;
        @(negedge clk);
        bus.data_available = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_start", bus.core_start, 4'b0000);
        chk("mr_rx", bus.jobs_rx, 16'd0);
        chk("mr_to", bus.rx_timeouts, 16'd0);
        chk("mr_drop", bus.jobs_dropped, 16'd0);
        chk("mr_level", bus.buf_level, 2'd0);
        n0 = log_g.size();
        repeat (8) @(negedge clk);
        chk("mr_no_start", log_g.size(), n0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
